store_buffer: RTL and testbench

Store queue between the core's memory stage and `store_unit`. It accepts byte, halfword and word store requests and rejects misaligned ones. Accepted stores are aligned into a word address, replicated data and a byte-enable mask, then held in a DEPTH-entry FIFO. The FIFO drains in order into `store_unit` through its `write_i`/`valid_o` handshake. A load-address hazard check lets the load path stall while a store to the same word is still pending.

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// In-order store queue between the memory stage and store_unit: aligns byte/half/word
// stores into word address + replicated data + byte enables, and flags load-address hazards.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic        misaligned_o,
  output logic        write_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  input  logic        valid_i,
  output logic        empty_o,
  input  logic [31:0] ld_addr_i,
  output logic        ld_hit_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          misaligned_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          hit_s;
  logic [31:0]   al_data_s;
  logic [3:0]    al_be_s;

  // Request decode: alignment of data/byte enables and misalignment detection
  always_comb begin
    al_data_s    = 32'h0000_0000;
    al_be_s      = 4'b0000;
    misaligned_s = 1'b0;
    case (size_i)
      2'd0: begin
        al_data_s = {4{data_i[7:0]}};
        al_be_s   = 4'b0001 << addr_i[1:0];
      end
      2'd1: begin
        al_data_s    = {2{data_i[15:0]}};
        al_be_s      = addr_i[1] ? 4'b1100 : 4'b0011;
        misaligned_s = addr_i[0];
      end
      2'd2: begin
        al_data_s    = data_i;
        al_be_s      = 4'b1111;
        misaligned_s = (addr_i[1:0] != 2'b00);
      end
      default: begin
        misaligned_s = 1'b1;
      end
    endcase
  end

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == {CW{1'b0}});
  // A full FIFO blocks the push even if the head pops this cycle.
  assign push_s  = req_i & ~full_s & ~misaligned_s;
  assign pop_s   = valid_i & ~empty_s;

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state and storage
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= 32'h0000_0000;
        data_q[i] <= 32'h0000_0000;
        be_q[i]   <= 4'b0000;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        addr_q[wr_ptr_q] <= {addr_i[31:2], 2'b00};
        data_q[wr_ptr_q] <= al_data_s;
        be_q[wr_ptr_q]   <= al_be_s;
      end
    end
  end

  // Load hazard: compare every occupied slot, including a head popping this cycle
  always_comb begin
    logic [PW-1:0] offs;
    hit_s = 1'b0;
    offs  = {PW{1'b0}};
    for (int i = 0; i < int'(DEPTH); i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ((CW'(offs) < count_q) && (addr_q[i][31:2] == ld_addr_i[31:2])) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign ready_o      = ~full_s;
  assign write_o      = ~empty_s;
  assign empty_o      = empty_s;
  assign misaligned_o = req_i & misaligned_s;
  assign ld_hit_o     = hit_s;
  assign addr_o       = addr_q[rd_ptr_q];
  assign data_o       = data_q[rd_ptr_q];
  assign be_o         = be_q[rd_ptr_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based model of the store queue.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        misaligned_o;
  logic        write_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  be_o;
  logic        valid_i;
  logic        empty_o;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;

  int errors = 0;
  int checks = 0;
  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .size_i(size_i), .addr_i(addr_i),
    .data_i(data_i), .ready_o(ready_o), .misaligned_o(misaligned_o), .write_o(write_o),
    .addr_o(addr_o), .data_o(data_o), .be_o(be_o), .valid_i(valid_i), .empty_o(empty_o),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t align(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int sh;
    sh = int'(a % 32'd4);
    e.addr = a - (a % 32'd4);
    e.be   = 4'b0000;
    e.data = 32'h0;
    if (sz == 2'd0) begin
      e.data = (d & 32'hFF) * 32'h0101_0101;
      e.be   = 4'(1 << sh);
    end else if (sz == 2'd1) begin
      e.data = (d & 32'hFFFF) * 32'h0001_0001;
      e.be   = (sh >= 2) ? 4'b1100 : 4'b0011;
    end else begin
      e.data = d;
      e.be   = 4'b1111;
    end
    return e;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_write"}, 32'(write_o), 32'd0);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_ldhit"}, 32'(ld_hit_o), 32'd0);
    chk({tag, "_addr"}, addr_o, 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
    chk({tag, "_be"}, 32'(be_o), 32'd0);
  endtask

  // One clock of stimulus: drive, compare against the model, clock, update the model.
  task automatic cyc(input logic rq, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic vl, input logic [31:0] ld);
    logic mis, hit, push, pop;
    ent_t e;
    req_i = rq; size_i = sz; addr_i = a; data_i = d; valid_i = vl; ld_addr_i = ld;
    #1;
    mis = (sz == 2'd3) || (sz == 2'd1 && (a % 32'd2) != 32'd0) ||
          (sz == 2'd2 && (a % 32'd4) != 32'd0);
    hit = 1'b0;
    foreach (q[i]) if ((q[i].addr / 32'd4) == (ld / 32'd4)) hit = 1'b1;
    chk("misaligned", 32'(misaligned_o), 32'(rq && mis));
    chk("ready", 32'(ready_o), 32'(q.size() < DEPTH));
    chk("write", 32'(write_o), 32'(q.size() != 0));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("ld_hit", 32'(ld_hit_o), 32'(hit));
    if (q.size() != 0) begin
      chk("head_addr", addr_o, q[0].addr);
      chk("head_data", data_o, q[0].data);
      chk("head_be", 32'(be_o), 32'(q[0].be));
    end
    push = rq && !mis && (q.size() < DEPTH);
    pop  = vl && (q.size() != 0);
    e = align(sz, a, d);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFF0);
  endtask

  initial begin
    int n;
    logic [31:0] a, ld;
    logic [1:0]  sz;
    rstn_i = 1'b0; req_i = 1'b0; size_i = 2'd0; addr_i = 32'h0; data_i = 32'h0;
    valid_i = 1'b0; ld_addr_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_misaligned", 32'(misaligned_o), 32'd0);
    @(negedge clk); rstn_i = 1'b1;
    @(posedge clk); #1;

    // Single word store then drain
    cyc(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("word_write", 32'(write_o), 32'd1);
    chk("word_addr", addr_o, 32'h100);
    chk("word_data", data_o, 32'hDEAD_BEEF);
    chk("word_be", 32'(be_o), 32'hF);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("word_empty_after_pop", 32'(empty_o), 32'd1);

    // Sub-word alignment
    cyc(1'b1, 2'd0, 32'h203, 32'h0000_00A5, 1'b0, 32'h0);
    chk("byte_data", data_o, 32'hA5A5_A5A5);
    chk("byte_be", 32'(be_o), 32'h8);
    chk("byte_addr", addr_o, 32'h200);
    cyc(1'b1, 2'd1, 32'h302, 32'h0000_1234, 1'b1, 32'h0);
    chk("half_data", data_o, 32'h1234_1234);
    chk("half_be", 32'(be_o), 32'hC);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Misaligned and reserved-size requests are rejected
    cyc(1'b1, 2'd1, 32'h101, 32'h1, 1'b0, 32'h0);
    cyc(1'b1, 2'd2, 32'h102, 32'h2, 1'b0, 32'h0);
    cyc(1'b1, 2'd3, 32'h100, 32'h3, 1'b0, 32'h0);
    idle();
    chk("misaligned_not_enqueued", 32'(write_o), 32'd0);

    // Fill to DEPTH, hold a fifth request, then stream 12 entries with concurrent pops
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 2'd2, 32'h1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0);
    chk("full_ready_low", 32'(ready_o), 32'd0);
    repeat (2) cyc(1'b1, 2'd2, 32'h1010, 32'hC0DE_0004, 1'b0, 32'h0);
    for (int i = 4; i < 16; i++) cyc(1'b1, 2'd2, 32'h1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, 32'h0);
    repeat (DEPTH + 1) cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("drained_empty", 32'(empty_o), 32'd1);

    // Load hazard
    cyc(1'b1, 2'd0, 32'h404, 32'h77, 1'b0, 32'h0);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h406);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h408);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h406);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h406);
    chk("hazard_cleared", 32'(ld_hit_o), 32'd0);

    // Asynchronous reset with three entries pending and valid_i toggling
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd2, 32'h2000 + 32'(i * 4), 32'hBEEF_0000 + 32'(i), 1'b0, 32'h2000);
    req_i = 1'b0; valid_i = 1'b1; ld_addr_i = 32'h2000;
    #1; rstn_i = 1'b0; #1;
    chk_reset_outputs("midreset");
    q.delete();
    @(posedge clk); valid_i = 1'b0; #1;
    chk_reset_outputs("midreset_held");
    @(negedge clk); rstn_i = 1'b1; valid_i = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 2'd0, 32'h3001, 32'h0000_005A, 1'b0, 32'h3000);
    chk("post_reset_data", data_o, 32'h5A5A_5A5A);
    chk("post_reset_be", 32'(be_o), 32'h2);
    chk("post_reset_addr", addr_o, 32'h3000);

    // Randomized traffic over a small address window to provoke hazards and wrap
    for (int k = 0; k < 400; k++) begin
      n  = $urandom_range(0, 9);
      sz = (n < 8) ? 2'(n % 3) : 2'd3;
      a  = 32'h400 + 32'($urandom_range(0, 31));
      ld = 32'h400 + 32'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), sz, a, $urandom, 1'($urandom_range(0, 2) != 0), ld);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
